// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, default timing
// parameters and the row/column to hex key map.
package keypad_pkg;

    localparam int SCAN_DIV_DEF     = 4800;
    localparam int DEBOUNCE_CNT_DEF = 960000;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Columns are active-low; the lowest-index pressed column wins.
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
module col_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns,
    output logic [3:0] columns_sync
);

    logic [3:0] sync_p0;
    logic [3:0] sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 4'b1111;
            sync_p1 <= 4'b1111;
        end else begin
            sync_p0 <= columns;
            sync_p1 <= sync_p0;
        end
    end

    assign columns_sync = sync_p1;

endmodule

// File: rtl/keypad_ctrl.sv
// 4x4 keypad scanner with press/release debounce and a two-digit history.
// Define KEYPAD_SYNC_EN to pass the columns through a 2-FF synchronizer.
module keypad_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit0,
    output logic [3:0] digit1
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DEB_W-1:0]    deb_cnt;
    logic [1:0]          row_idx;
    logic [1:0]          col_idx;
    logic [3:0]          col_eff;
    logic                col_low;
    logic                any_low;
    logic                scan_done;
    logic                deb_done;
    logic [3:0]          new_code;

`ifdef KEYPAD_SYNC_EN
    col_sync u_col_sync (
        .clk          (clk),
        .reset        (reset),
        .columns      (columns),
        .columns_sync (col_eff)
    );
`else
    assign col_eff = columns;
`endif

    assign col_low   = ~col_eff[col_idx];
    assign any_low   = (col_eff != 4'b1111);
    assign scan_done = (scan_cnt == SCAN_LAST);
    assign deb_done  = (deb_cnt == DEB_LAST);
    assign new_code  = key_lookup(row_idx, col_idx);

    always_ff @(posedge clk) begin
        if (reset) state <= SCAN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:     if (scan_done && any_low) state_nxt = DEBOUNCE;
            DEBOUNCE: if (!col_low)             state_nxt = SCAN;
                      else if (deb_done)        state_nxt = HELD;
            HELD:     if (!col_low)             state_nxt = RELEASE;
            RELEASE:  if (col_low)              state_nxt = HELD;
                      else if (deb_done)        state_nxt = SCAN;
            default:                            state_nxt = SCAN;
        endcase
    end

    // Counters only advance below their terminal value, so they never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            digit0    <= 4'h0;
            digit1    <= 4'h0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    deb_cnt <= '0;
                    if (scan_done) begin
                        scan_cnt <= '0;
                        if (any_low) col_idx <= lowest_low(col_eff);
                        else         row_idx <= row_idx + 2'd1;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!col_low) begin
                        deb_cnt <= '0;
                        row_idx <= row_idx + 2'd1;
                    end else if (deb_done) begin
                        deb_cnt   <= '0;
                        key_valid <= 1'b1;
                        key_code  <= new_code;
                        digit1    <= digit0;
                        digit0    <= new_code;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    deb_cnt <= '0;
                end
                RELEASE: begin
                    if (col_low) begin
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        deb_cnt <= '0;
                        row_idx <= row_idx + 2'd1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: deb_cnt <= '0;
            endcase
        end
    end

    // The latched row stays driven outside SCAN because row_idx only moves on exit.
    always_comb begin
        rows = ~(4'b0001 << row_idx);
    end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Self-checking bench for keypad_ctrl: emulated 4x4 key matrix, behavioural
// reference model, per-cycle compare plus directed and randomized scenarios.
module tb_keypad_ctrl;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int PH_SCAN = 0, PH_DEB = 1, PH_HELD = 2, PH_REL = 3;
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = 16'h0;
    logic [3:0]  columns;
    logic [3:0]  rows;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  digit0;
    logic [3:0]  digit1;

    int errors = 0;
    int checks = 0;
    int kv_seen = 0;

    keypad_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .columns   (columns),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digit0    (digit0),
        .digit1    (digit1)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column low while its row is driven low.
    function automatic logic [3:0] pad(input logic [15:0] pr, input logic [3:0] rw);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (rw[r] == 1'b0 && pr[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    assign columns = pad(pressed, rows);

    function automatic int lowest(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] key(input int r, input int c);
        return 16'(1) << (r*4 + c);
    endfunction

    // Reference model
    int         m_ph = PH_SCAN, m_row = 0, m_col = 0, m_tick = 0, m_run = 0;
    bit         m_init = 0;
    logic       m_kv = 1'b0;
    logic [3:0] m_code = 4'h0, m_d0 = 4'h0, m_d1 = 4'h0;
    logic [3:0] m_now, m_eff, m_h0 = 4'hF, m_h1 = 4'hF;

    function automatic logic [3:0] exp_rows(input int r);
        return 4'(~(32'd1 << r));
    endfunction

    always @(posedge clk) begin
        m_now = pad(pressed, exp_rows(m_row));
`ifdef KEYPAD_SYNC_EN
        m_eff = m_h1;
        m_h1  = m_h0;
        m_h0  = m_now;
`else
        m_eff = m_now;
`endif
        if (reset) begin
            m_init = 1; m_ph = PH_SCAN; m_row = 0; m_col = 0; m_tick = 0; m_run = 0;
            m_kv = 1'b0; m_code = 4'h0; m_d0 = 4'h0; m_d1 = 4'h0;
            m_h0 = 4'hF; m_h1 = 4'hF;
        end else begin
            m_kv = 1'b0;
            case (m_ph)
                PH_SCAN: begin
                    if (m_tick == SD - 1) begin
                        m_tick = 0;
                        if (m_eff != 4'hF) begin
                            m_col = lowest(m_eff); m_run = 0; m_ph = PH_DEB;
                        end else m_row = (m_row + 1) % 4;
                    end else m_tick++;
                end
                PH_DEB: begin
                    if (m_eff[m_col]) begin
                        m_ph = PH_SCAN; m_row = (m_row + 1) % 4;
                    end else begin
                        m_run++;
                        if (m_run == DC) begin
                            m_kv = 1'b1; m_code = KEYMAP[m_row*4 + m_col];
                            m_d1 = m_d0; m_d0 = m_code; m_ph = PH_HELD;
                        end
                    end
                end
                PH_HELD: if (m_eff[m_col]) begin m_run = 0; m_ph = PH_REL; end
                default: begin
                    if (!m_eff[m_col]) m_ph = PH_HELD;
                    else begin
                        m_run++;
                        if (m_run == DC) begin m_ph = PH_SCAN; m_row = (m_row + 1) % 4; end
                    end
                end
            endcase
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (m_init) begin
            checks++;
            if (rows !== exp_rows(m_row) || key_valid !== m_kv || key_code !== m_code ||
                digit0 !== m_d0 || digit1 !== m_d1) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t rows=%b/%b kv=%b/%b code=%h/%h d0=%h/%h d1=%h/%h (got/want)",
                         $time, rows, exp_rows(m_row), key_valid, m_kv, key_code, m_code,
                         digit0, m_d0, digit1, m_d1);
            end
            if (key_valid === 1'b1) kv_seen++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_change(input logic [3:0] from);
        int n;
        n = 0;
        while (rows === from && n < 4*SD) begin cyc(1); n++; end
    endtask

    int base;
    int n;

    initial begin
        reset = 1'b1;
        pressed = 16'h0;
        cyc(2);
        chk("rst_rows", rows, 4'b1110);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_d0", digit0, 4'h0);
        chk("rst_d1", digit1, 4'h0);
        reset = 1'b0;

        // Steady press of key 5
        base = kv_seen;
        pressed = key(1, 1);
        cyc(60);
        chk("hold5_pulses", kv_seen - base, 1);
        chk("hold5_code", key_code, 4'h5);
        chk("hold5_d0", digit0, 4'h5);
        chk("hold5_d1", digit1, 4'h0);
        chk("model_d0_5", m_d0, 4'h5);
        cyc(100);
        chk("hold5_no_repeat", kv_seen - base, 1);
        pressed = 16'h0;
        cyc(40);

        // Short bounce: no pulse, scanning resumes
        base = kv_seen;
        pressed = key(1, 1);
        cyc(5);
        pressed = 16'h0;
        cyc(30);
        chk("short_no_pulse", kv_seen - base, 0);
        n = 0;
        while (rows !== 4'b1011 && n < 100) begin cyc(1); n++; end
        chk("seq_row2", rows, 4'b1011);
        wait_change(4'b1011);
        chk("seq_row3", rows, 4'b0111);
        wait_change(4'b0111);
        chk("seq_row0", rows, 4'b1110);

        // Press/release 1 then A
        base = kv_seen;
        pressed = key(0, 0); cyc(60);
        pressed = 16'h0;     cyc(40);
        pressed = key(0, 3); cyc(60);
        pressed = 16'h0;     cyc(40);
        chk("seq_d1", digit1, 4'h1);
        chk("seq_d0", digit0, 4'hA);
        chk("seq_pulses", kv_seen - base, 2);
        chk("model_d1_1", m_d1, 4'h1);

        // Two columns of row 0 together: lowest column wins
        pressed = key(0, 0) | key(0, 2);
        cyc(60);
        chk("multi_code", key_code, 4'h1);
        pressed = 16'h0;
        cyc(40);

        // Reset while HELD
        pressed = key(1, 1);
        cyc(60);
        reset = 1'b1;
        pressed = 16'h0;
        cyc(1);
        chk("held_rst_rows", rows, 4'b1110);
        chk("held_rst_d0", digit0, 4'h0);
        chk("held_rst_d1", digit1, 4'h0);
        chk("held_rst_code", key_code, 4'h0);
        chk("held_rst_kv", key_valid, 1'b0);
        reset = 1'b0;
        base = kv_seen;
        cyc(40);
        chk("held_rst_no_pulse", kv_seen - base, 0);

        // Randomized presses, bounces and occasional resets
        for (int i = 0; i < 40; i++) begin
            pressed = key($urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) pressed = pressed | key($urandom_range(0, 3), $urandom_range(0, 3));
            cyc($urandom_range(1, 50));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            pressed = 16'h0;
            cyc($urandom_range(1, 40));
        end

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_ctrl.md
KEYPAD_CTRL -- requirements
Module: keypad_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4800, meaning clk cycles per row step (10 kHz at 48 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 960000, meaning clk cycles of stable level required on press and on release (20 ms).
REQ-003 SHALL have port clk  in  1  system clock (HSOSC, 48 MHz).
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port columns  in  4  keypad columns, active-low (pulled up), asynchronous.
REQ-006 SHALL have port rows  out  4  row drive, one-cold, active-low.
REQ-007 SHALL have port key_valid  out  1  one-cycle pulse for each debounced new press.
REQ-008 SHALL have port key_code  out  4  hex code of the last accepted key.
REQ-009 SHALL have ports digit0 and digit1  out  4 each  display digits; digit0 is newest, digit1 previous.

Function
REQ-010 SHALL map keys as follows: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = E 0 F D; entries are listed by column index 0..3.
REQ-011 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 SCAN SHALL drive rows = ~(1<<row_idx) and count SCAN_DIV cycles; on the last cycle it SHALL sample the columns.
REQ-013 In SCAN, if any sampled column is low, the FSM SHALL latch row_idx and the lowest-index low column, then go to DEBOUNCE.
REQ-014 In SCAN, if no sampled column is low, row_idx SHALL increment with wrap 3 -> 0.
REQ-015 DEBOUNCE SHALL hold the latched row and count while the latched column stays low.
REQ-016 In DEBOUNCE, if the latched column goes high, the counter SHALL clear, the FSM SHALL return to SCAN and row_idx SHALL advance.
REQ-017 On the DEBOUNCE_CNT-th consecutive low cycle, the next edge SHALL assert key_valid for exactly one cycle and load key_code.
REQ-018 On that same edge, digit1 SHALL take digit0, digit0 SHALL take the new code, and the FSM SHALL enter HELD.
REQ-019 HELD SHALL hold the row and issue no further key_valid; other keys SHALL be ignored; the latched column going high SHALL move the FSM to RELEASE.
REQ-020 RELEASE SHALL count consecutive high cycles of the latched column.
REQ-021 In RELEASE, a low return SHALL clear the counter and go back to HELD with no new pulse.
REQ-022 After DEBOUNCE_CNT high cycles in RELEASE, the FSM SHALL go to SCAN with row_idx advanced.
REQ-023 Counter widths SHALL be $clog2 of their parameter.
REQ-024 Counters SHALL saturate at their terminal value, never wrap.

Reset
REQ-025 On reset: state=SCAN, row_idx=0, rows=4'b1110, key_valid=0, key_code=0, digit0=0, digit1=0, all counters=0.
REQ-026 Reset asserted in any state, including mid-debounce and HELD, SHALL take effect on the next clk edge.
REQ-027 A pending press SHALL be discarded by reset, and no key_valid SHALL follow.

Configuration
REQ-028 Macro KEYPAD_SYNC_EN defined: columns SHALL pass through a 2-FF synchronizer (reset to 4'b1111) before all FSM use, adding 2 cycles of input latency.
REQ-029 Macro KEYPAD_SYNC_EN undefined: columns SHALL be used directly (simulation only), with no added latency.

Structure
REQ-030 Package keypad_pkg SHALL hold the state enum, the key-map lookup function, and the SCAN_DIV/DEBOUNCE_CNT defaults.
REQ-031 Sub-module col_sync SHALL implement the 2-FF synchronizer and be instantiated only under KEYPAD_SYNC_EN.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, KEYPAD_SYNC_EN defined)
REQ-032 Reset for 2 cycles -> rows=1110, key_valid=0, digit0=digit1=0.
REQ-033 Hold row1/col1 low steadily -> exactly one key_valid with key_code=5, digit0=5, digit1=0; no further pulse over 100 held cycles.
REQ-034 Press row1/col1 low for 5 cycles then release -> no key_valid; rows resume cycling 1011 -> 0111 -> 1110.
REQ-035 Press and release 1, then press and release A -> digit1=1, digit0=A, with two key_valid pulses total.
REQ-036 Hold row0 col0 and col2 low together -> key_code=1.
REQ-037 Assert reset during HELD -> next cycle rows=1110, digits=0, no key_valid.
